// File: rtl/mmu_resp.sv
`default_nettype none
// ============================================================================
// Module  : mmu_resp
// Brief   : Arbitrates inst fetch, load and store onto one word backend port.
//           Define MMU_RESP_IBUF_EN for a one-entry instruction buffer.
// Revision: 1.0
// ============================================================================
module mmu_resp #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INST_RDEN,
    input  logic [31:0] INST_RIADDR,
    output logic [31:0] INST_ROADDR,
    output logic        INST_RVALID,
    output logic [31:0] INST_RDATA,
    input  logic        DATA_RDEN,
    input  logic [31:0] DATA_RIADDR,
    output logic [31:0] DATA_ROADDR,
    output logic        DATA_RVALID,
    output logic [31:0] DATA_RDATA,
    input  logic        DATA_WREN,
    input  logic [3:0]  DATA_WSTRB,
    input  logic [31:0] DATA_WADDR,
    input  logic [31:0] DATA_WDATA,
    output logic        MEM_WAIT,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [3:0]  MEM_STRB,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_DREAD = 3'd2,
        S_IREAD = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [15:0] c_WAIT_LAST = 16'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic        ld_pend_q, ld_pend_d;
    logic [31:0] ld_addr_q, ld_addr_d;
    logic [31:0] if_addr_q, if_addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  strb_q, strb_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wait_q, wait_d;
    logic        irv_q, irv_d;
    logic [31:0] iroaddr_q, iroaddr_d;
    logic [31:0] irdata_q, irdata_d;
    logic        drv_q, drv_d;
    logic [31:0] droaddr_q, droaddr_d;
    logic [31:0] drdata_q, drdata_d;

    logic        w_done;
    logic        w_tmo;
    logic        w_ib_hit;
    logic [31:0] w_ib_data;
    logic        w_unused;

    // An ACK only counts while a request is actually outstanding.
    assign w_done   = req_q && MEM_ACK;
    assign w_tmo    = req_q && !MEM_ACK && (cnt_q == c_WAIT_LAST);
    assign w_unused = ^DATA_WADDR[1:0];

`ifdef MMU_RESP_IBUF_EN
    logic        ib_valid_q;
    logic [29:0] ib_tag_q;
    logic [31:0] ib_data_q;
    logic        w_ib_fill;
    logic        w_ib_inval;

    assign w_ib_hit   = ib_valid_q && (ib_tag_q == INST_RIADDR[31:2]);
    assign w_ib_data  = ib_data_q;
    assign w_ib_fill  = (state_q == S_IREAD) && w_done;
    assign w_ib_inval = (state_q == S_IDLE) && DATA_WREN && (ib_tag_q == DATA_WADDR[31:2]);

    always_ff @(posedge CLK) begin
        if (RST) begin
            ib_valid_q <= 1'b0;
            ib_tag_q   <= '0;
            ib_data_q  <= '0;
        end else if (w_ib_inval) begin
            ib_valid_q <= 1'b0;
        end else if (w_ib_fill) begin
            ib_valid_q <= 1'b1;
            ib_tag_q   <= if_addr_q[31:2];
            ib_data_q  <= MEM_RDATA;
        end
    end
`else
    assign w_ib_hit  = 1'b0;
    assign w_ib_data = '0;
`endif

    always_comb begin
        state_d   = state_q;
        ld_pend_d = ld_pend_q;
        ld_addr_d = ld_addr_q;
        if_addr_d = if_addr_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        strb_d    = strb_q;
        wdata_d   = wdata_q;
        irv_d     = 1'b0;
        iroaddr_d = iroaddr_q;
        irdata_d  = irdata_q;
        drv_d     = 1'b0;
        droaddr_d = droaddr_q;
        drdata_d  = drdata_q;
        cnt_d     = (req_q && !MEM_ACK && !w_tmo) ? cnt_q + 16'd1 : 16'd0;

        case (state_q)
            S_IDLE: begin
                if (DATA_WREN) begin
                    state_d = S_WRITE;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    addr_d  = {DATA_WADDR[31:2], 2'b00};
                    strb_d  = DATA_WSTRB;
                    wdata_d = DATA_WDATA;
                    if (DATA_RDEN) begin
                        ld_pend_d = 1'b1;
                        ld_addr_d = DATA_RIADDR;
                    end
                end else if (DATA_RDEN) begin
                    state_d   = S_DREAD;
                    ld_pend_d = 1'b1;
                    ld_addr_d = DATA_RIADDR;
                    req_d     = 1'b1;
                    we_d      = 1'b0;
                    addr_d    = {DATA_RIADDR[31:2], 2'b00};
                    strb_d    = 4'hF;
                end else if (INST_RDEN) begin
                    if_addr_d = INST_RIADDR;
                    if (w_ib_hit) begin
                        state_d   = S_RESP;
                        irv_d     = 1'b1;
                        iroaddr_d = INST_RIADDR;
                        irdata_d  = w_ib_data;
                    end else begin
                        state_d = S_IREAD;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = {INST_RIADDR[31:2], 2'b00};
                        strb_d  = 4'hF;
                    end
                end
            end
            S_WRITE: begin
                if (w_done || w_tmo) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = ld_pend_q ? S_DREAD : S_IDLE;
                end
            end
            S_DREAD: begin
                // Arriving from WRITE the request line is low; launch the load here.
                if (!req_q) begin
                    req_d  = 1'b1;
                    we_d   = 1'b0;
                    addr_d = {ld_addr_q[31:2], 2'b00};
                    strb_d = 4'hF;
                end else if (w_done || w_tmo) begin
                    req_d     = 1'b0;
                    ld_pend_d = 1'b0;
                    drv_d     = 1'b1;
                    droaddr_d = ld_addr_q;
                    drdata_d  = w_done ? MEM_RDATA : 32'h0;
                    state_d   = S_RESP;
                end
            end
            S_IREAD: begin
                if (w_done || w_tmo) begin
                    req_d     = 1'b0;
                    irv_d     = 1'b1;
                    iroaddr_d = if_addr_q;
                    irdata_d  = w_done ? MEM_RDATA : 32'h0;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Only data-side activity stalls the core; fetches report via INST_RVALID.
        wait_d = (state_d == S_WRITE) || (state_d == S_DREAD) || ld_pend_d ||
                 ((state_d == S_RESP) && drv_d);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            ld_pend_q <= 1'b0;
            ld_addr_q <= '0;
            if_addr_q <= '0;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            strb_q    <= '0;
            wdata_q   <= '0;
            wait_q    <= 1'b0;
            irv_q     <= 1'b0;
            iroaddr_q <= '0;
            irdata_q  <= '0;
            drv_q     <= 1'b0;
            droaddr_q <= '0;
            drdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            ld_pend_q <= ld_pend_d;
            ld_addr_q <= ld_addr_d;
            if_addr_q <= if_addr_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            strb_q    <= strb_d;
            wdata_q   <= wdata_d;
            wait_q    <= wait_d;
            irv_q     <= irv_d;
            iroaddr_q <= iroaddr_d;
            irdata_q  <= irdata_d;
            drv_q     <= drv_d;
            droaddr_q <= droaddr_d;
            drdata_q  <= drdata_d;
        end
    end

    assign INST_ROADDR = iroaddr_q;
    assign INST_RVALID = irv_q;
    assign INST_RDATA  = irdata_q;
    assign DATA_ROADDR = droaddr_q;
    assign DATA_RVALID = drv_q;
    assign DATA_RDATA  = drdata_q;
    assign MEM_WAIT    = wait_q;
    assign MEM_REQ     = req_q;
    assign MEM_WE      = we_q;
    assign MEM_ADDR    = addr_q;
    assign MEM_STRB    = strb_q;
    assign MEM_WDATA   = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mmu_resp.sv
`default_nettype none
// ============================================================================
// Module  : tb_mmu_resp
// Brief   : Scoreboard bench for mmu_resp with a behavioural word backend.
// Revision: 1.0
// ============================================================================
module tb_mmu_resp;

    localparam int unsigned MAX_WAIT = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        INST_RDEN = 1'b0;
    logic [31:0] INST_RIADDR = '0;
    logic [31:0] INST_ROADDR;
    logic        INST_RVALID;
    logic [31:0] INST_RDATA;
    logic        DATA_RDEN = 1'b0;
    logic [31:0] DATA_RIADDR = '0;
    logic [31:0] DATA_ROADDR;
    logic        DATA_RVALID;
    logic [31:0] DATA_RDATA;
    logic        DATA_WREN = 1'b0;
    logic [3:0]  DATA_WSTRB = '0;
    logic [31:0] DATA_WADDR = '0;
    logic [31:0] DATA_WDATA = '0;
    logic        MEM_WAIT;
    logic        MEM_REQ;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [3:0]  MEM_STRB;
    logic [31:0] MEM_WDATA;
    logic        MEM_ACK = 1'b0;
    logic [31:0] MEM_RDATA = '0;

    mmu_resp #(.MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .RST(RST),
        .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR),
        .INST_ROADDR(INST_ROADDR), .INST_RVALID(INST_RVALID), .INST_RDATA(INST_RDATA),
        .DATA_RDEN(DATA_RDEN), .DATA_RIADDR(DATA_RIADDR),
        .DATA_ROADDR(DATA_ROADDR), .DATA_RVALID(DATA_RVALID), .DATA_RDATA(DATA_RDATA),
        .DATA_WREN(DATA_WREN), .DATA_WSTRB(DATA_WSTRB),
        .DATA_WADDR(DATA_WADDR), .DATA_WDATA(DATA_WDATA),
        .MEM_WAIT(MEM_WAIT), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
        .MEM_ADDR(MEM_ADDR), .MEM_STRB(MEM_STRB), .MEM_WDATA(MEM_WDATA),
        .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } txn_t;

    resp_t       exp_i[$];
    resp_t       exp_d[$];
    txn_t        exp_m[$];
    logic [31:0] mem_model [logic [31:0]];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ack_delay = 0;
    bit   force_ack = 1'b0;
    int   req_cnt = 0;
    int   last_req_len = 0;
    int   rv_cyc_i = 0;
    int   rv_cyc_d = 0;
    int   issue_cyc = 0;
    logic req_prev = 1'b0;
    txn_t cur;

    initial forever #5 CLK = ~CLK;
    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem_model.exists(a) ? mem_model[a] : 32'h0;
    endfunction

    task automatic mem_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] w;
        w = mem_read(a);
        for (int b = 0; b < 4; b++)
            if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
        mem_model[a] = w;
    endtask

    task automatic exp_mem(input logic we, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.strb = s; t.wdata = d;
        exp_m.push_back(t);
    endtask

    task automatic exp_inst(input logic [31:0] a, input logic [31:0] d);
        resp_t r;
        r.addr = a; r.data = d;
        exp_i.push_back(r);
    endtask

    task automatic exp_data(input logic [31:0] a, input logic [31:0] d);
        resp_t r;
        r.addr = a; r.data = d;
        exp_d.push_back(r);
    endtask

    // Backend responder first, then response/transaction monitor, on the falling edge.
    initial begin
        resp_t r;
        txn_t  t;
        forever begin
            @(negedge CLK);
            if (force_ack) begin
                MEM_ACK = 1'b1;
            end else if (MEM_REQ) begin
                if (ack_delay >= 0 && req_cnt == ack_delay) begin
                    MEM_ACK = 1'b1;
                    if (MEM_WE) mem_write(MEM_ADDR, MEM_STRB, MEM_WDATA);
                    else        MEM_RDATA = mem_read(MEM_ADDR);
                end else begin
                    MEM_ACK = 1'b0;
                end
                req_cnt++;
            end else begin
                MEM_ACK = 1'b0;
                if (req_cnt != 0) last_req_len = req_cnt;
                req_cnt = 0;
            end

            if (INST_RVALID) begin
                rv_cyc_i = cyc;
                if (exp_i.size() == 0) chk("inst_unexpected_rvalid", 32'd1, 32'd0);
                else begin
                    r = exp_i.pop_front();
                    chk("inst_roaddr", INST_ROADDR, r.addr);
                    chk("inst_rdata", INST_RDATA, r.data);
                end
            end
            if (DATA_RVALID) begin
                rv_cyc_d = cyc;
                if (exp_d.size() == 0) chk("data_unexpected_rvalid", 32'd1, 32'd0);
                else begin
                    r = exp_d.pop_front();
                    chk("data_roaddr", DATA_ROADDR, r.addr);
                    chk("data_rdata", DATA_RDATA, r.data);
                end
            end
            if (MEM_REQ && !req_prev) begin
                cur.we = MEM_WE; cur.addr = MEM_ADDR; cur.strb = MEM_STRB; cur.wdata = MEM_WDATA;
                if (exp_m.size() == 0) chk("mem_unexpected_req", 32'd1, 32'd0);
                else begin
                    t = exp_m.pop_front();
                    chk("mem_we", {31'd0, MEM_WE}, {31'd0, t.we});
                    chk("mem_addr", MEM_ADDR, t.addr);
                    chk("mem_strb", {28'd0, MEM_STRB}, {28'd0, t.strb});
                    if (t.we) chk("mem_wdata", MEM_WDATA, t.wdata);
                end
            end
            if (MEM_REQ && MEM_ACK) begin
                chk("mem_addr_stable", MEM_ADDR, cur.addr);
                chk("mem_ctl_stable", {27'd0, MEM_WE, MEM_STRB}, {27'd0, cur.we, cur.strb});
            end
            req_prev = MEM_REQ;
        end
    end

    task automatic issue(input logic ird, input logic [31:0] ia,
                         input logic drd, input logic [31:0] da,
                         input logic wr, input logic [31:0] wa,
                         input logic [3:0] ws, input logic [31:0] wd);
        @(posedge CLK); #1;
        INST_RDEN = ird; INST_RIADDR = ia;
        DATA_RDEN = drd; DATA_RIADDR = da;
        DATA_WREN = wr;  DATA_WADDR = wa; DATA_WSTRB = ws; DATA_WDATA = wd;
        issue_cyc = cyc;
        @(posedge CLK); #1;
        INST_RDEN = 1'b0; DATA_RDEN = 1'b0; DATA_WREN = 1'b0;
    endtask

    task automatic settle(input string name);
        repeat (20) @(posedge CLK);
        chk({name, "_inst_q_empty"}, exp_i.size(), 32'd0);
        chk({name, "_data_q_empty"}, exp_d.size(), 32'd0);
        chk({name, "_mem_q_empty"}, exp_m.size(), 32'd0);
    endtask

    initial begin
        logic flag;
        logic seen;

        mem_model[32'h100] = 32'hDEADBEEF;
        mem_model[32'h200] = 32'hAAAAAAAA;
        mem_model[32'h204] = 32'hCAFEF00D;
        mem_model[32'h040] = 32'h12345678;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_flags", {27'd0, MEM_REQ, MEM_WE, MEM_WAIT, INST_RVALID, DATA_RVALID}, 32'd0);
        chk("reset_words", INST_ROADDR | INST_RDATA | DATA_ROADDR | DATA_RDATA | MEM_ADDR | MEM_WDATA, 32'd0);
        chk("reset_strb", {28'd0, MEM_STRB}, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // Plain fetch, ACK in the second request cycle.
        ack_delay = 1;
        exp_mem(1'b0, 32'h100, 4'hF, 32'h0);
        exp_inst(32'h100, 32'hDEADBEEF);
        issue(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        flag = 1'b0;
        repeat (12) begin
            @(negedge CLK);
            if (MEM_WAIT) flag = 1'b1;
        end
        chk("fetch_mem_wait_low", {31'd0, flag}, 32'd0);
        settle("fetch");
        chk("fetch_latency", rv_cyc_i - issue_cyc, 32'd3);

        // Same-cycle store and load: store first, then load, stall held throughout.
        exp_mem(1'b1, 32'h200, 4'h3, 32'h11223344);
        exp_mem(1'b0, 32'h204, 4'hF, 32'h0);
        exp_data(32'h204, 32'hCAFEF00D);
        issue(1'b0, 32'h0, 1'b1, 32'h204, 1'b1, 32'h200, 4'h3, 32'h11223344);
        flag = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge CLK);
            if (!MEM_WAIT) flag = 1'b1;
            if (DATA_RVALID) seen = 1'b1;
        end
        chk("st_ld_wait_gap", {31'd0, flag}, 32'd0);
        chk("st_ld_rvalid_seen", {31'd0, seen}, 32'd1);
        @(negedge CLK);
        chk("st_ld_wait_release", {31'd0, MEM_WAIT}, 32'd0);
        settle("st_ld");

        // Read back the partially written word with minimum latency.
        ack_delay = 0;
        exp_mem(1'b0, 32'h200, 4'hF, 32'h0);
        exp_data(32'h200, 32'hAAAA3344);
        issue(1'b0, 32'h0, 1'b1, 32'h200, 1'b0, 32'h0, 4'h0, 32'h0);
        settle("readback");
        chk("load_latency", rv_cyc_d - issue_cyc, 32'd2);

        // Backend never answers: abort after MAX_WAIT request cycles.
        ack_delay = -1;
        exp_mem(1'b0, 32'h300, 4'hF, 32'h0);
        exp_data(32'h303, 32'h0);
        issue(1'b0, 32'h0, 1'b1, 32'h303, 1'b0, 32'h0, 4'h0, 32'h0);
        settle("timeout");
        chk("timeout_req_len", last_req_len, MAX_WAIT);

        // Load beats fetch; a one-cycle fetch request is dropped.
        ack_delay = 2;
        exp_mem(1'b0, 32'h204, 4'hF, 32'h0);
        exp_data(32'h204, 32'hCAFEF00D);
        issue(1'b1, 32'h600, 1'b1, 32'h204, 1'b0, 32'h0, 4'h0, 32'h0);
        settle("priority");

        // Reset mid-fetch, then a late ACK.
        ack_delay = -1;
        exp_mem(1'b0, 32'h500, 4'hF, 32'h0);
        issue(1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        force_ack = 1'b1;
        flag = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            if (MEM_REQ || INST_RVALID || DATA_RVALID) flag = 1'b1;
        end
        force_ack = 1'b0;
        chk("rst_late_ack_quiet", {31'd0, flag}, 32'd0);
        chk("rst_words", INST_ROADDR | INST_RDATA | DATA_ROADDR | DATA_RDATA | MEM_ADDR | MEM_WDATA, 32'd0);
        chk("rst_ctl", {26'd0, MEM_STRB, MEM_WE, MEM_WAIT}, 32'd0);
        settle("rst");

        // Repeated fetch of one word, then a store to it, then refetch.
        ack_delay = 1;
        exp_mem(1'b0, 32'h040, 4'hF, 32'h0);
        exp_inst(32'h040, 32'h12345678);
        issue(1'b1, 32'h040, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        settle("ibuf_first");
`ifndef MMU_RESP_IBUF_EN
        exp_mem(1'b0, 32'h040, 4'hF, 32'h0);
`endif
        exp_inst(32'h042, 32'h12345678);
        issue(1'b1, 32'h042, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        settle("ibuf_second");
        exp_mem(1'b1, 32'h040, 4'hF, 32'h0BADF00D);
        issue(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h041, 4'hF, 32'h0BADF00D);
        settle("ibuf_store");
        exp_mem(1'b0, 32'h040, 4'hF, 32'h0);
        exp_inst(32'h040, 32'h0BADF00D);
        issue(1'b1, 32'h040, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0);
        settle("ibuf_refetch");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
